// File: rtl/status_tracker_if.sv
// Status-in / record-out bundle between the core, the status tracker and the host.
// The tracker takes the slave view; the core/host side takes the master view.
interface status_tracker_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [1:0]       i_status;
  logic             i_status_valid;
  logic             o_rec_valid;
  logic             i_rec_ready;
  logic [CNT_W+1:0] o_rec_data;
  logic [LW-1:0]    o_level;
  logic [CNT_W-1:0] o_r_cnt;
  logic [CNT_W-1:0] o_i_cnt;
  logic             o_ovf_flag;
  logic             o_drop;
  logic             o_done;

  modport slave (
    input  i_status, i_status_valid, i_rec_ready,
    output o_rec_valid, o_rec_data, o_level, o_r_cnt, o_i_cnt,
           o_ovf_flag, o_drop, o_done
  );

  modport master (
    output i_status, i_status_valid, i_rec_ready,
    input  o_rec_valid, o_rec_data, o_level, o_r_cnt, o_i_cnt,
           o_ovf_flag, o_drop, o_done
  );
endinterface

// File: rtl/status_tracker.sv
// Sequence-stamps core status events into a record FIFO, counts successes and
// latches the first terminal status, raising o_done once the FIFO has drained.
module status_tracker #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  status_tracker_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {RUN, TERM, HALT} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    lvl_q;
  logic [CNT_W-1:0] seq_q, r_q, i_q;
  logic             ovf_q, drop_q;
  logic [CNT_W+1:0] mem_q [DEPTH];

  logic ev, pop, full, push;

  // Only RUN captures events; TERM/HALT swallow the core's repeated MIPS_END.
  assign ev   = (state_q == RUN) && bus.i_status_valid;
  assign pop  = (lvl_q != '0) && bus.i_rec_ready;
  assign full = (lvl_q == LW'(DEPTH));
  assign push = ev && (!full || pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (ev && bus.i_status[1]) state_d = TERM;
      TERM:    if (lvl_q == '0)           state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      seq_q   <= '0;
      r_q     <= '0;
      i_q     <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
      // Cleared so the empty-FIFO head reads 0 after reset.
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem_q[wr_q] <= {bus.i_status, seq_q};
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
      if (ev) begin
        seq_q <= seq_q + 1'b1;
        if (bus.i_status == 2'd0 && r_q != '1) r_q <= r_q + 1'b1;
        if (bus.i_status == 2'd1 && i_q != '1) i_q <= i_q + 1'b1;
        if (bus.i_status == 2'd2) ovf_q <= 1'b1;
        if (!push) drop_q <= 1'b1;
      end
    end
  end

  assign bus.o_rec_valid = (lvl_q != '0);
  assign bus.o_rec_data  = mem_q[rd_q];
  assign bus.o_level     = lvl_q;
  assign bus.o_r_cnt     = r_q;
  assign bus.o_i_cnt     = i_q;
  assign bus.o_ovf_flag  = ovf_q;
  assign bus.o_drop      = drop_q;
  assign bus.o_done      = (state_q == HALT);
endmodule

// File: tb/tb_status_tracker.sv
// Random and directed status streams against a queue-based reference; a separate
// monitor pops expected records whenever the host handshake completes.
module tb_status_tracker;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int SMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  status_tracker_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
  status_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  int nvec = 0;
  int nmis = 0;

  // Reference state: records the host should see, in order.
  logic [CNT_W+1:0] exp_q[$];
  int m_lvl, m_seq, m_r, m_i, m_ph;  // m_ph: 0 running, 1 terminated, 2 done
  bit m_ovf, m_drop;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("level",     int'(bus.o_level),     m_lvl);
    chk("rec_valid", int'(bus.o_rec_valid), int'(m_lvl != 0));
    chk("r_cnt",     int'(bus.o_r_cnt),     m_r);
    chk("i_cnt",     int'(bus.o_i_cnt),     m_i);
    chk("ovf_flag",  int'(bus.o_ovf_flag),  int'(m_ovf));
    chk("drop",      int'(bus.o_drop),      int'(m_drop));
    chk("done",      int'(bus.o_done),      int'(m_ph == 2));
  endtask

  task automatic cycle(input bit v, input logic [1:0] s, input bit r);
    bit pop;
    int nph;
    logic [CNT_W+1:0] rec;
    @(negedge clk);
    check_outputs();
    bus.i_status_valid = v;
    bus.i_status       = s;
    bus.i_rec_ready    = r;
    pop = (m_lvl > 0) && r;
    nph = m_ph;
    if (m_ph == 0 && v) begin
      if (m_lvl < DEPTH || pop) begin
        rec = {s, CNT_W'(m_seq)};
        exp_q.push_back(rec);
        m_lvl++;
      end else begin
        m_drop = 1'b1;
      end
      m_seq = (m_seq + 1) % (SMAX + 1);
      if (s == 2'd0 && m_r < SMAX) m_r++;
      if (s == 2'd1 && m_i < SMAX) m_i++;
      if (s >= 2'd2) begin
        nph = 1;
        if (s == 2'd2) m_ovf = 1'b1;
      end
    end else if (m_ph == 1 && m_lvl == 0) begin
      nph = 2;
    end
    if (pop) m_lvl--;
    m_ph = nph;
  endtask

  task automatic do_reset(input bit expect_empty);
    @(negedge clk);
    if (expect_empty) chk("records_left", exp_q.size(), 0);
    #1;
    rst_n = 1'b0;
    bus.i_status_valid = 1'b0;
    bus.i_status       = 2'd0;
    bus.i_rec_ready    = 1'b0;
    #1;
    chk("rst_rec_valid", int'(bus.o_rec_valid), 0);
    chk("rst_rec_data",  int'(bus.o_rec_data),  0);
    chk("rst_level",     int'(bus.o_level),     0);
    chk("rst_r_cnt",     int'(bus.o_r_cnt),     0);
    chk("rst_i_cnt",     int'(bus.o_i_cnt),     0);
    chk("rst_ovf",       int'(bus.o_ovf_flag),  0);
    chk("rst_drop",      int'(bus.o_drop),      0);
    chk("rst_done",      int'(bus.o_done),      0);
    exp_q.delete();
    m_lvl = 0; m_seq = 0; m_r = 0; m_i = 0; m_ph = 0;
    m_ovf = 1'b0; m_drop = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 2'd0, 1'b1);
  endtask

  // Monitor: a handshake seen here completes at the next rising edge.
  initial begin
    logic [CNT_W+1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.o_rec_valid && bus.i_rec_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_record", int'(bus.o_rec_data), -1);
        end else begin
          e = exp_q.pop_front();
          chk("rec_data", int'(bus.o_rec_data), int'(e));
        end
      end
    end
  end

  initial begin
    logic [1:0] s;
    int pick;
    bus.i_status_valid = 1'b0;
    bus.i_status       = 2'd0;
    bus.i_rec_ready    = 1'b0;

    // Basic sequence 0,1,0,3
    do_reset(1'b0);
    cycle(1, 2'd0, 1); cycle(1, 2'd1, 1); cycle(1, 2'd0, 1); cycle(1, 2'd3, 1);
    drain(6);

    // Repeating MIPS_END
    do_reset(1'b1);
    for (int k = 0; k < 20; k++) cycle(1, 2'd3, 1);
    drain(3);

    // Overflow terminal, trailing successes ignored
    do_reset(1'b1);
    cycle(1, 2'd1, 1); cycle(1, 2'd2, 1);
    for (int k = 0; k < 5; k++) cycle(1, 2'd0, 1);
    drain(4);

    // Fill, push+pop at full, then overflow the FIFO
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) cycle(1, 2'd0, 0);
    cycle(1, 2'd1, 1);
    cycle(1, 2'd0, 0); cycle(1, 2'd0, 0);
    drain(DEPTH + 3);

    // Counter saturation and seq wrap
    do_reset(1'b1);
    for (int k = 0; k < 20; k++) cycle(1, 2'd1, 1);
    drain(4);

    // Reset while full with drop set, then restart
    do_reset(1'b1);
    for (int k = 0; k < 10; k++) cycle(1, 2'd0, 0);
    do_reset(1'b0);
    cycle(1, 2'd0, 1); cycle(1, 2'd3, 1);
    drain(4);

    // Random episodes
    for (int ep = 0; ep < 8; ep++) begin
      do_reset(1'b1);
      for (int k = 0; k < 40; k++) begin
        pick = $urandom_range(0, 99);
        s = (pick < 45) ? 2'd0 : (pick < 90) ? 2'd1 : (pick < 95) ? 2'd2 : 2'd3;
        cycle($urandom_range(0, 3) != 0, s, $urandom_range(0, 2) != 0);
      end
      drain(DEPTH + 4);
    end

    do_reset(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
